// File: rtl/mem_line_responder_if.sv
// Cacheline read channel between the instruction cache (master) and the
// memory-side responder (slave): single-cycle read requests going out and
// one-cycle line returns coming back.
interface mem_line_responder_if #(
  parameter int unsigned PADDR_W = 20,
  parameter int unsigned LINE_W  = 128
);
  logic               mem_req_ren;
  logic [PADDR_W-1:0] mem_req_addr;
  logic               mem_rec_en;
  logic [PADDR_W-1:0] mem_rec_addr;
  logic [LINE_W-1:0]  mem_rec_cacheline;

  modport master (
    output mem_req_ren, mem_req_addr,
    input  mem_rec_en, mem_rec_addr, mem_rec_cacheline
  );

  modport slave (
    input  mem_req_ren, mem_req_addr,
    output mem_rec_en, mem_rec_addr, mem_rec_cacheline
  );
endinterface

// File: rtl/mem_line_responder.sv
// Memory-side responder for cacheline reads. Requests are queued in a small
// FIFO and served one at a time from a backing line array after a fixed
// latency. Each line is returned with its aligned address as a one-cycle
// pulse. A loader port fills the array.
// Optional build macro MEM_RESP_MERGE_EN: a request for a line that is already
// queued or in flight is absorbed into that pending response.
module mem_line_responder #(
  parameter int unsigned PADDR_W   = 20,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned MEM_LINES = 1024,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_line_responder_if.slave   bus,
  input  logic                  ld_wen,
  input  logic [PADDR_W-1:0]    ld_addr,
  input  logic [LINE_W-1:0]     ld_line,
  output logic                  q_full,
  output logic                  overflow
);

  localparam int unsigned LA_W  = PADDR_W - 4;
  localparam int unsigned IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [LA_W-1:0]    r_fifo [QDEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;

  logic [LA_W-1:0]    r_inflight;
  logic [CNT_W-1:0]   r_cnt;

  logic [LINE_W-1:0]  r_mem [MEM_LINES];

  logic [PADDR_W-1:0] r_rec_addr;
  logic [LINE_W-1:0]  r_rec_line;
  logic               r_overflow;

  logic [LA_W-1:0]    w_req_line;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_ld_idx;
  logic               w_empty;
  logic               w_full;
  logic               w_deq;
  logic               w_rd;
  logic               w_hit;
  logic               w_enq;
  logic               w_drop;
  logic               w_unused_ok;

  assign w_req_line = bus.mem_req_addr[PADDR_W-1:4];
  assign w_rd_idx   = IDX_W'(r_inflight % LA_W'(MEM_LINES));
  assign w_ld_idx   = IDX_W'(ld_addr[PADDR_W-1:4] % LA_W'(MEM_LINES));
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (PTR_W+1)'(QDEPTH));

  // Byte-offset bits carry no meaning for line-granular requests and loads.
  assign w_unused_ok = &{1'b0, bus.mem_req_addr[3:0], ld_addr[3:0]};

`ifdef MEM_RESP_MERGE_EN
  // Detect a request for a line that is already pending (queued or in flight).
  always_comb begin
    w_hit = 1'b0;
    if ((r_state != S_IDLE) && (r_inflight == w_req_line)) begin
      w_hit = 1'b1;
    end
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (((PTR_W+1)'(i) < r_count) &&
          (r_fifo[PTR_W'(r_rd_ptr + PTR_W'(i))] == w_req_line)) begin
        w_hit = 1'b1;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_enq  = bus.mem_req_ren && !w_hit && (!w_full || w_deq);
  assign w_drop = bus.mem_req_ren && !w_hit && w_full && !w_deq;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, head pop and array read strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_deq       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_rd        = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; emptied on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; validity comes from the occupancy count only.
  always_ff @(posedge clk) begin
    if (w_enq) r_fifo[r_wr_ptr] <= w_req_line;
  end

  // In-flight line and latency countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
      r_cnt      <= '0;
    end else if (w_deq) begin
      r_inflight <= r_fifo[r_rd_ptr];
      r_cnt      <= CNT_W'(LATENCY - 1);
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Response registers; they hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rec_addr <= '0;
      r_rec_line <= '0;
    end else if (w_rd) begin
      r_rec_addr <= {r_inflight, 4'h0};
      r_rec_line <= r_mem[w_rd_idx];
    end
  end

  // Backing array loader; a same-edge read still sees the previous contents.
  always_ff @(posedge clk) begin
    if (ld_wen) r_mem[w_ld_idx] <= ld_line;
  end

  // Sticky record of a dropped request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.mem_rec_en        = (r_state == S_RESP);
  assign bus.mem_rec_addr      = r_rec_addr;
  assign bus.mem_rec_cacheline = r_rec_line;
  assign q_full                = w_full;
  assign overflow              = r_overflow;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference
// that schedules each accepted request in time and snapshots array data.
module tb_mem_line_responder;

  localparam int unsigned PADDR_W   = 20;
  localparam int unsigned LINE_W    = 128;
  localparam int unsigned MEM_LINES = 1024;
  localparam int unsigned LATENCY   = 4;
  localparam int unsigned QDEPTH    = 4;
  localparam int          NCYC      = 4096;

`ifdef MEM_RESP_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ld_wen;
  logic [PADDR_W-1:0] ld_addr;
  logic [LINE_W-1:0]  ld_line;
  logic               q_full;
  logic               overflow;

  always #5 clk = ~clk;

  mem_line_responder_if #(.PADDR_W(PADDR_W), .LINE_W(LINE_W)) bus ();

  mem_line_responder #(
    .PADDR_W  (PADDR_W),
    .LINE_W   (LINE_W),
    .MEM_LINES(MEM_LINES),
    .LATENCY  (LATENCY),
    .QDEPTH   (QDEPTH)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ld_wen  (ld_wen),
    .ld_addr (ld_addr),
    .ld_line (ld_line),
    .q_full  (q_full),
    .overflow(overflow)
  );

  // One accepted request: its line, the cycle it was issued, the cycle it
  // leaves the queue, the cycle its response pulses, and the data it returns.
  typedef struct {
    logic [15:0]  line;
    int           enq;
    int           pop;
    int           resp;
    logic [127:0] data;
  } req_t;

  req_t         mq[$];
  logic [127:0] mmem [MEM_LINES];
  int           cyc;
  int           last_resp;
  bit           m_ovf;
  logic [19:0]  m_addr;
  logic [127:0] m_line;

  bit           obs_en   [NCYC];
  logic [19:0]  obs_addr [NCYC];
  logic [127:0] obs_line [NCYC];
  bit           obs_full [NCYC];
  bit           obs_ovf  [NCYC];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int count_resp(input int from, input int upto);
    int n = 0;
    for (int c = from; c <= upto; c++) begin
      if (c >= 0 && c < NCYC && obs_en[c]) n++;
    end
    return n;
  endfunction

  // One clock cycle: check outputs against the reference, drive this cycle's
  // inputs, then advance the reference.
  task automatic step(input bit ren, input logic [19:0] raddr,
                      input bit wen, input logic [19:0] waddr,
                      input logic [127:0] wline);
    int          cnt;
    int          pop;
    bit          pop_now;
    bit          hit;
    bit          exp_en;
    logic [15:0] rl;
    req_t        e;
    @(negedge clk);
    exp_en  = 1'b0;
    cnt     = 0;
    pop_now = 1'b0;
    hit     = 1'b0;
    rl      = raddr[19:4];
    foreach (mq[i]) begin
      if (mq[i].resp == cyc) begin
        exp_en = 1'b1;
        m_addr = {mq[i].line, 4'h0};
        m_line = mq[i].data;
      end
      if (mq[i].pop >= cyc) cnt++;
      if (mq[i].pop == cyc) pop_now = 1'b1;
      if (mq[i].resp >= cyc && mq[i].line == rl) hit = 1'b1;
    end
    if (cyc < NCYC) begin
      obs_en[cyc]   = bus.mem_rec_en;
      obs_addr[cyc] = bus.mem_rec_addr;
      obs_line[cyc] = bus.mem_rec_cacheline;
      obs_full[cyc] = q_full;
      obs_ovf[cyc]  = overflow;
    end
    chk("rec_en",   {127'b0, bus.mem_rec_en}, {127'b0, exp_en});
    chk("rec_addr", {108'b0, bus.mem_rec_addr}, {108'b0, m_addr});
    chk("rec_line", bus.mem_rec_cacheline, m_line);
    chk("q_full",   {127'b0, q_full}, {127'b0, (cnt == int'(QDEPTH))});
    chk("overflow", {127'b0, overflow}, {127'b0, m_ovf});

    bus.mem_req_ren  = ren;
    bus.mem_req_addr = raddr;
    ld_wen           = wen;
    ld_addr          = waddr;
    ld_line          = wline;

    if (ren && !(MERGE && hit)) begin
      if (cnt < int'(QDEPTH) || pop_now) begin
        pop    = (cyc + 1 > last_resp + 1) ? cyc + 1 : last_resp + 1;
        e.line = rl;
        e.enq  = cyc;
        e.pop  = pop;
        e.resp = pop + int'(LATENCY) + 1;
        e.data = '0;
        last_resp = e.resp;
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    // The array is sampled on the edge closing the cycle before the pulse,
    // before this cycle's loader write lands.
    foreach (mq[i]) begin
      if (mq[i].resp == cyc + 1) mq[i].data = mmem[int'(mq[i].line) % MEM_LINES];
    end
    if (wen) mmem[int'(waddr[19:4]) % MEM_LINES] = wline;
    while (mq.size() > 0 && mq[0].resp < cyc) void'(mq.pop_front());
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic req(input logic [19:0] a);
    step(1'b1, a, 1'b0, '0, '0);
  endtask

  task automatic load(input logic [19:0] a, input logic [127:0] d);
    step(1'b0, '0, 1'b1, a, d);
  endtask

  // Asynchronous reset assertion between edges; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    rst              = 1'b0;
    bus.mem_req_ren  = 1'b0;
    ld_wen           = 1'b0;
    #1;
    chk({tag, "_en"},   {127'b0, bus.mem_rec_en}, '0);
    chk({tag, "_addr"}, {108'b0, bus.mem_rec_addr}, '0);
    chk({tag, "_line"}, bus.mem_rec_cacheline, '0);
    chk({tag, "_full"}, {127'b0, q_full}, '0);
    chk({tag, "_ovf"},  {127'b0, overflow}, '0);
    mq.delete();
    m_ovf     = 1'b0;
    m_addr    = '0;
    m_line    = '0;
    last_resp = -100;
  endtask

  initial begin
    int          t0;
    int          t1;
    logic [15:0] ln;
    logic [127:0] c_t1;
    logic [127:0] c_old;
    logic [127:0] c_new;

    c_t1  = 128'h000000DD_000000CC_000000BB_000000AA;
    c_old = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    c_new = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;

    bus.mem_req_ren  = 1'b0;
    bus.mem_req_addr = '0;
    ld_wen           = 1'b0;
    ld_addr          = '0;
    ld_line          = '0;
    cyc              = 0;
    last_resp        = -100;
    m_ovf            = 1'b0;
    m_addr           = '0;
    m_line           = '0;

    #12;
    chk("rst0_en",   {127'b0, bus.mem_rec_en}, '0);
    chk("rst0_addr", {108'b0, bus.mem_rec_addr}, '0);
    chk("rst0_line", bus.mem_rec_cacheline, '0);
    chk("rst0_full", {127'b0, q_full}, '0);
    chk("rst0_ovf",  {127'b0, overflow}, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 64; i++) load({4'h0, 12'(i), 4'h0}, rnd_line());
    load(20'h00120, c_t1);
    idle(2);

    // Single request: pulse exactly LATENCY+2 cycles later.
    t0 = cyc;
    req(20'h0012C);
    idle(10);
    chk("t1_en_c5", {127'b0, obs_en[t0+5]}, '0);
    chk("t1_en_c6", {127'b0, obs_en[t0+6]}, 128'd1);
    chk("t1_en_c7", {127'b0, obs_en[t0+7]}, '0);
    chk("t1_addr",  {108'b0, obs_addr[t0+6]}, {108'b0, 20'h00120});
    chk("t1_line",  obs_line[t0+6], c_t1);
    chk("t1_count", count_resp(t0, t0 + 10), 128'd1);

    // Back-to-back requests: in order, six cycles apart.
    t0 = cyc;
    req(20'h00100);
    req(20'h00200);
    req(20'h00300);
    idle(20);
    chk("t2_en_a",   {127'b0, obs_en[t0+6]},  128'd1);
    chk("t2_en_b",   {127'b0, obs_en[t0+12]}, 128'd1);
    chk("t2_en_c",   {127'b0, obs_en[t0+18]}, 128'd1);
    chk("t2_addr_a", {108'b0, obs_addr[t0+6]},  {108'b0, 20'h00100});
    chk("t2_addr_b", {108'b0, obs_addr[t0+12]}, {108'b0, 20'h00200});
    chk("t2_addr_c", {108'b0, obs_addr[t0+18]}, {108'b0, 20'h00300});
    chk("t2_count",  count_resp(t0, t0 + 22), 128'd3);

    // Six distinct requests: fills the queue and drops one.
    t0 = cyc;
    req(20'h00010);
    req(20'h00020);
    req(20'h00030);
    req(20'h00060);
    req(20'h00070);
    req(20'h00080);
    idle(40);
    chk("t3_full_c4", {127'b0, obs_full[t0+4]}, '0);
    chk("t3_full_c5", {127'b0, obs_full[t0+5]}, 128'd1);
    chk("t3_ovf_c5",  {127'b0, obs_ovf[t0+5]},  '0);
    chk("t3_ovf_c6",  {127'b0, obs_ovf[t0+6]},  128'd1);
    chk("t3_count",   count_resp(t0, t0 + 45), 128'(QDEPTH + 1));

    // Reset with one line in flight and two queued: nothing comes back.
    t0 = cyc;
    req(20'h00090);
    req(20'h000A0);
    req(20'h000B0);
    idle(1);
    pulse_reset("t4_rst");
    idle(2);
    rst = 1'b1;
    idle(25);
    chk("t4_count", count_resp(t0, cyc - 1), '0);
    chk("t4_ovf",   {127'b0, obs_ovf[cyc-1]}, '0);

    // Three requests for the same line.
    t0 = cyc;
    req(20'h00040);
    req(20'h00040);
    req(20'h00040);
    idle(25);
    chk("t5_count", count_resp(t0, t0 + 27), MERGE ? 128'd1 : 128'd3);

    // Loader write on the same edge as the array read returns old data.
    load(20'h00050, c_old);
    idle(3);
    t0 = cyc;
    req(20'h00050);
    idle(4);
    load(20'h00050, c_new);
    idle(4);
    chk("t6_en_old",   {127'b0, obs_en[t0+6]}, 128'd1);
    chk("t6_line_old", obs_line[t0+6], c_old);
    t1 = cyc;
    req(20'h00058);
    idle(8);
    chk("t6_en_new",   {127'b0, obs_en[t1+6]}, 128'd1);
    chk("t6_line_new", obs_line[t1+6], c_new);

    // Randomized traffic over a few aliased lines, with one mid-run reset.
    for (int k = 0; k < 1200; k++) begin
      bit          r_en;
      bit          w_en;
      logic [19:0] ra;
      logic [19:0] wa;
      if (k == 600) begin
        pulse_reset("rnd_rst");
        idle(2);
        rst = 1'b1;
      end
      r_en = ($urandom % 100) < 45;
      w_en = ($urandom % 100) < 20;
      ln   = 16'($urandom_range(0, 3) * MEM_LINES + $urandom_range(0, 7));
      ra   = {ln, 4'($urandom)};
      ln   = 16'($urandom_range(0, 3) * MEM_LINES + $urandom_range(0, 7));
      wa   = {ln, 4'($urandom)};
      step(r_en, ra, w_en, wa, rnd_line());
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the cacheline read protocol driven by the instruction cache.
- Accepts single-cycle read requests and queues them in a small FIFO.
- Services requests one at a time from a backing line array, after a fixed access latency.
- Returns each line with its address as a one-cycle receive pulse; a loader write port fills the array.

Parameters:
- PADDR_W, 20, physical address width; bits [3:0] are the byte offset within a 16-byte line.
- LINE_W, 128, cacheline width (4 words of 32 bits).
- MEM_LINES, 1024, backing array depth in lines; indexed by line address modulo MEM_LINES.
- LATENCY, 4, cycles from dequeue to response, minimum 1.
- QDEPTH, 4, request FIFO depth, power of two, minimum 2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req_ren  in  1  read request strobe, one request per asserted cycle
- mem_req_addr  in  PADDR_W  request address; offset bits ignored
- mem_rec_en  out  1  response valid, one-cycle pulse
- mem_rec_addr  out  PADDR_W  line-aligned address of the returned line (offset bits 0)
- mem_rec_cacheline  out  LINE_W  returned line data
- ld_wen  in  1  loader write strobe
- ld_addr  in  PADDR_W  loader line address; offset bits ignored
- ld_line  in  LINE_W  loader write data
- q_full  out  1  FIFO holds QDEPTH entries
- overflow  out  1  sticky: a request was dropped because the FIFO was full

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied, FSM to IDLE, latency counter 0.
  - mem_rec_en=0, mem_rec_addr=0, mem_rec_cacheline=0, q_full=0, overflow=0.
  - Backing array contents not reset.
  - Reset mid-operation discards all queued and in-flight requests; no response follows reset release.
- Enqueue:
  - When mem_req_ren=1 and FIFO not full, the line address (mem_req_addr with offset cleared) is written at the tail.
  - When mem_req_ren=1 and FIFO full, the request is dropped and overflow is set; it clears only on reset.
  - Enqueue and dequeue in the same cycle on a full FIFO: the dequeue frees space first, so the request is accepted.
- FSM:
  - IDLE: if FIFO non-empty, pop head into the in-flight address register, load counter with LATENCY-1, go to WAIT. A request enqueued while the FIFO is empty is popped on the following cycle at the earliest.
  - WAIT: decrement counter. At 0, read the array at the in-flight address into mem_rec_cacheline, drive mem_rec_addr, go to RESP.
  - RESP: mem_rec_en=1 for exactly this cycle, then IDLE.
  - Outputs hold their last values when mem_rec_en=0.
  - Sustained throughput: one response per LATENCY+2 cycles.
  - Request-to-response latency from an empty idle FIFO: LATENCY+2 cycles (request cycle t, mem_rec_en at cycle t+LATENCY+2).
- Loader:
  - ld_wen writes ld_line at array index (ld_addr>>4) mod MEM_LINES on the clock edge.
  - If a write lands on the same edge as the WAIT->RESP array read of the same line, the read returns the old data; writes on earlier edges are visible.
- Ordering: responses are returned strictly in FIFO order.
- q_full is combinational from the FIFO count.

Optional Feature:
- Macro: MEM_RESP_MERGE_EN.
- Defined: an incoming request whose line address equals any valid FIFO entry or the in-flight line (state WAIT or RESP) is merged. It is not enqueued, overflow is not set even when the FIFO is full, and a single response serves all merged requesters. This absorbs repeated miss requests for the same line.
- Not defined: every accepted request is enqueued and produces its own response, duplicates included.

Test Plan:
- Load line 0x12 with 0x000000DD_000000CC_000000BB_000000AA; request addr 0x0012C with LATENCY=4 at cycle 0 -> mem_rec_en high at cycle 6 only, mem_rec_addr=0x00120, line matches.
- Back-to-back requests to 0x00100, 0x00200, 0x00300 in cycles 0-2 -> three responses in that order, spaced 6 cycles apart, starting at cycle 6.
- Issue 6 requests to distinct lines on consecutive cycles with QDEPTH=4 -> q_full asserts, overflow=1 after the dropped request, exactly QDEPTH+1 responses (the first pops into flight at cycle 1).
- Deassert rst while a request is in WAIT and two are queued -> mem_rec_en and all outputs 0 immediately, no response after rst returns high, overflow=0.
- With MEM_RESP_MERGE_EN, request 0x00040 three times in cycles 0-2 -> one response; without the macro -> three responses for 0x00040.
- ld_wen to line 0x05 on the same edge as the WAIT->RESP read of line 0x05 -> old data returned; a re-request returns the new data.
